// File: rtl/led_pkg.sv
// Shared types and width helpers for the GRB LED-strip frame sequencer.
package led_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEND  = 2'd1,
        LATCH = 2'd2
    } state_e;

    // Ceiling log2, usable in parameter and port-width expressions.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result++;
        end
        return result;
    endfunction

    // Counter width for a modulus; never narrower than one bit.
    function automatic int width_of(input int modulus);
        return (clog2(modulus) < 1) ? 1 : clog2(modulus);
    endfunction

endpackage

// File: rtl/mod_counter.sv
// Modulo-MOD up-counter with synchronous clear and a wrap strobe on the
// increment that rolls it back to zero.
module mod_counter #(
    parameter int MOD = 2,
    parameter int W   = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count,
    output logic         wrap
);

    localparam logic [W-1:0] LAST = W'(MOD - 1);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        wrap    = inc && (count_q == LAST);
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (wrap) begin
            count_d = '0;
        end else if (inc) begin
            count_d = count_q + W'(1);
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together on the edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/led_frame_sequencer.sv
// Bit/LED/frame sequencer for the GRB strip driver: indexes serialised bits,
// times the post-frame latch gap and counts completed frames.
module led_frame_sequencer
    import led_pkg::*;
#(
    parameter int BITS_PER_LED = 24,
    parameter int NUM_LEDS     = 10,
    parameter int LATCH_CYCLES = 2500,
    parameter int FRAME_W      = 8
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                start,
    input  logic                                abort,
    input  logic                                repeat_en,
    input  logic                                bit_done,
    output logic [width_of(BITS_PER_LED)-1:0]   bit_idx,
    output logic [width_of(NUM_LEDS)-1:0]       led_idx,
    output logic                                busy,
    output logic                                sending,
    output logic                                latching,
    output logic                                last_bit,
    output logic                                last_led,
    output logic                                frame_done,
    output logic [FRAME_W-1:0]                  frame_cnt
);

    localparam int BIT_W = width_of(BITS_PER_LED);
    localparam int LED_W = width_of(NUM_LEDS);
    localparam int LAT_W = width_of(LATCH_CYCLES);

    state_e               state_q;
    state_e               state_d;
    logic                 frame_done_q;
    logic                 frame_done_d;
    logic [FRAME_W-1:0]   frame_cnt_q;
    logic [FRAME_W-1:0]   frame_cnt_d;

    logic                 in_send;
    logic                 in_latch;
    logic                 bit_wrap;
    logic                 led_wrap;
    logic                 lat_wrap;
    logic [LAT_W-1:0]     lat_count;
    logic                 unused_lat;

    assign in_send  = (state_q == SEND);
    assign in_latch = (state_q == LATCH);

    mod_counter #(.MOD(BITS_PER_LED), .W(BIT_W)) u_bit_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (abort),
        .inc   (in_send && bit_done),
        .count (bit_idx),
        .wrap  (bit_wrap)
    );

    // The LED index only advances when the bit index rolls over.
    mod_counter #(.MOD(NUM_LEDS), .W(LED_W)) u_led_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (abort),
        .inc   (bit_wrap),
        .count (led_idx),
        .wrap  (led_wrap)
    );

    mod_counter #(.MOD(LATCH_CYCLES), .W(LAT_W)) u_lat_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (abort || led_wrap),
        .inc   (in_latch),
        .count (lat_count),
        .wrap  (lat_wrap)
    );

    assign unused_lat = ^lat_count;

    always_comb begin
        state_d      = state_q;
        frame_done_d = 1'b0;
        frame_cnt_d  = frame_cnt_q;
        if (abort) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:  if (start)    state_d = SEND;
                SEND:  if (led_wrap) state_d = LATCH;
                LATCH: begin
                    if (lat_wrap) begin
                        frame_done_d = 1'b1;
                        frame_cnt_d  = frame_cnt_q + FRAME_W'(1);
                        state_d      = repeat_en ? SEND : IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            frame_done_q <= 1'b0;
            frame_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            frame_done_q <= frame_done_d;
            frame_cnt_q  <= frame_cnt_d;
        end
    end

    assign busy       = in_send || in_latch;
    assign sending    = in_send;
    assign latching   = in_latch;
    assign last_bit   = in_send && (bit_idx == BIT_W'(BITS_PER_LED - 1));
    assign last_led   = in_send && (led_idx == LED_W'(NUM_LEDS - 1));
    assign frame_done = frame_done_q;
    assign frame_cnt  = frame_cnt_q;

endmodule
